// File: rtl/servo_pwm_rx_pkg.sv
// Shared types, default tick constants and the width-to-position mapping
// for the RC servo pulse decoder.
package servo_pwm_rx_pkg;

    typedef enum logic [1:0] {
        ST_ARM       = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEASURE   = 2'd2
    } state_e;

    localparam int WIDTH_W = 10;
    localparam int POS_W   = 8;

    localparam int DEF_TICK_CYCLES   = 47;
    localparam int DEF_OFFSET        = 256;
    localparam int DEF_MIN_TICKS     = 128;
    localparam int DEF_MAX_TICKS     = 768;
    localparam int DEF_TIMEOUT_TICKS = 6400;

    // Signed 11-bit difference, clamped into the 8-bit position code.
    function automatic logic [POS_W-1:0] width_to_pos(input logic [WIDTH_W-1:0] width,
                                                      input logic [WIDTH_W:0]   offset);
        logic signed [WIDTH_W:0] diff;
        diff = $signed({1'b0, width}) - $signed(offset);
        if (diff[WIDTH_W]) return '0;
        if (diff > 11'sd255) return '1;
        return diff[POS_W-1:0];
    endfunction

endpackage

// File: rtl/servo_pwm_rx_if.sv
// Pulse input and decoded position outputs of the servo pulse receiver.
interface servo_pwm_rx_if;
    import servo_pwm_rx_pkg::*;

    logic             servo_in;
    logic [POS_W-1:0] pos;
    logic             valid;
    logic             err;
    logic             locked;

    modport master (input servo_in, output pos, valid, err, locked);
    modport slave  (output servo_in, input pos, valid, err, locked);

endinterface

// File: rtl/servo_tick_prescaler.sv
// Modulo-TICK_CYCLES counter producing a one-cycle tick on each wrap;
// a synchronous clear restarts the phase and suppresses that cycle's tick.
module servo_tick_prescaler #(
    parameter int TICK_CYCLES = 47
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;

    assign wrap   = (cnt_q == CNT_W'(TICK_CYCLES - 1));
    assign tick_o = wrap & ~clear_i;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || wrap) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/servo_pwm_rx.sv
// RC servo pulse-width decoder: synchronizes the input, measures each high
// pulse in prescaled ticks and reports position, validity, errors and lock.
module servo_pwm_rx
    import servo_pwm_rx_pkg::*;
#(
    parameter int TICK_CYCLES   = DEF_TICK_CYCLES,
    parameter int OFFSET        = DEF_OFFSET,
    parameter int MIN_TICKS     = DEF_MIN_TICKS,
    parameter int MAX_TICKS     = DEF_MAX_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic            clk,
    input  logic            rst,
    servo_pwm_rx_if.master  bus
);

    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [WIDTH_W-1:0] MIN_W = WIDTH_W'(MIN_TICKS);
    localparam logic [WIDTH_W-1:0] MAX_W = WIDTH_W'(MAX_TICKS);
    localparam logic [WIDTH_W:0]   OFF_W = (WIDTH_W + 1)'(OFFSET);

    logic sync1_q, sync2_q, prev_q;
    logic rise, fall, tick;

    state_e               state_q, state_d;
    logic [WIDTH_W-1:0]   width_q, width_d, width_inc;
    logic [TO_W-1:0]      to_q, to_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 locked_q, locked_d;
    logic                 to_hit;

    // Chain resets high so a pulse already in progress at reset release
    // never looks like a fresh rise; ARM only exits on a genuine low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= bus.servo_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    servo_tick_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_presc (
        .clk     (clk),
        .rst     (rst),
        .clear_i (rise),
        .tick_o  (tick)
    );

    // Including this cycle's tick makes width = floor(high cycles / TICK_CYCLES).
    assign width_inc = (tick && width_q <= MAX_W) ? width_q + 1'b1 : width_q;
    assign to_hit    = ~rise & tick & (to_q == TO_W'(TIMEOUT_TICKS - 1));

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        pos_d    = pos_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        locked_d = locked_q;
        to_d     = to_q;

        if (rise)                                     to_d = '0;
        else if (tick && to_q < TO_W'(TIMEOUT_TICKS)) to_d = to_q + 1'b1;
        if (to_hit) locked_d = 1'b0;

        case (state_q)
            ST_ARM: begin
                if (!sync2_q) state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (rise) begin
                    width_d = '0;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                width_d = width_inc;
                if (width_inc > MAX_W) begin
                    err_d   = 1'b1;
                    state_d = ST_ARM;
                end else if (fall) begin
                    if (width_inc >= MIN_W) begin
                        pos_d    = width_to_pos(width_inc, OFF_W);
                        valid_d  = 1'b1;
                        locked_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_WAIT_RISE;
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_ARM;
            width_q  <= '0;
            to_q     <= '0;
            pos_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            to_q     <= to_d;
            pos_q    <= pos_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign bus.pos    = pos_q;
    assign bus.valid  = valid_q;
    assign bus.err    = err_q;
    assign bus.locked = locked_q;

endmodule

// File: tb/tb_servo_pwm_rx.sv
// Directed and randomized pulse trains against a pulse-width reference model,
// using scaled-down tick constants to keep runs short.
module tb_servo_pwm_rx;

    localparam int TC   = 3;
    localparam int OFF  = 16;
    localparam int MINT = 8;
    localparam int MAXT = 300;
    localparam int TOT  = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    servo_pwm_rx_if bus ();

    servo_pwm_rx #(
        .TICK_CYCLES   (TC),
        .OFFSET        (OFF),
        .MIN_TICKS     (MINT),
        .MAX_TICKS     (MAXT),
        .TIMEOUT_TICKS (TOT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int n_valid = 0, n_err = 0, n_both = 0;
    int exp_pos = 0;
    int exp_locked = 0;

    always @(negedge clk) begin
        if (bus.valid === 1'b1) n_valid++;
        if (bus.err === 1'b1) n_err++;
        if (bus.valid === 1'b1 && bus.err === 1'b1) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_pos(input int w);
        int p;
        p = w - OFF;
        if (p < 0) p = 0;
        if (p > 255) p = 255;
        return p;
    endfunction

    // High for h clocks, low for gap clocks, then compare against the model.
    task automatic pulse(input string tag, input int h, input int gap);
        int v0, e0, w, ev, ee;
        v0 = n_valid;
        e0 = n_err;
        bus.servo_in = 1'b1;
        repeat (h) @(posedge clk);
        #1 bus.servo_in = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        w = h / TC;
        if (w >= MINT && w <= MAXT) begin
            ev = 1; ee = 0;
            exp_pos = model_pos(w);
            exp_locked = 1;
        end else begin
            ev = 0; ee = 1;
        end
        chk({tag, ".valid"}, n_valid - v0, ev);
        chk({tag, ".err"}, n_err - e0, ee);
        chk({tag, ".pos"}, bus.pos, exp_pos);
        chk({tag, ".locked"}, bus.locked, exp_locked);
    endtask

    initial begin
        int cat, w, h, v0, e0;
        bus.servo_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst.pos", bus.pos, 0);
        chk("rst.valid", bus.valid, 0);
        chk("rst.err", bus.err, 0);
        chk("rst.locked", bus.locked, 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        pulse("mid", (OFF + 126) * TC + 1, 150);
        pulse("mid2", (OFF + 126) * TC, 150);
        pulse("glitch", 5 * TC, 150);
        pulse("clamp_lo", (OFF - 1) * TC + 2, 150);
        pulse("min_edge", MINT * TC, 150);
        pulse("below_min", MINT * TC - 1, 150);
        pulse("pos254", (OFF + 254) * TC, 150);
        pulse("max_edge", MAXT * TC + TC - 1, 150);
        pulse("max_plus1", (MAXT + 1) * TC, 150);
        pulse("stuck_hi", (MAXT + 1) * TC + 500, 150);
        pulse("after_hi", (OFF + 126) * TC, 150);

        // Stuck low: lock must hold until TOT ticks after the last rise, then drop.
        bus.servo_in = 1'b1;
        repeat (100 * TC) @(posedge clk);
        #1 bus.servo_in = 1'b0;
        exp_pos = model_pos(100);
        repeat (TOT * TC - 100 * TC - 4) @(posedge clk);
        #1;
        chk("to.before", bus.locked, 1);
        chk("to.pos", bus.pos, exp_pos);
        repeat (10) @(posedge clk);
        #1;
        chk("to.after", bus.locked, 0);
        exp_locked = 0;
        pulse("relock", (OFF + 126) * TC, 150);

        // Reset mid-pulse, released while high: that pulse must be ignored.
        bus.servo_in = 1'b1;
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        v0 = n_valid;
        e0 = n_err;
        repeat (30 * TC) @(posedge clk);
        #1 bus.servo_in = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("mrst.valid", n_valid - v0, 0);
        chk("mrst.err", n_err - e0, 0);
        chk("mrst.pos", bus.pos, 0);
        chk("mrst.locked", bus.locked, 0);
        exp_pos = 0;
        exp_locked = 0;
        pulse("post_rst", (OFF + 126) * TC, 150);

        for (int i = 0; i < 24; i++) begin
            cat = $urandom_range(0, 9);
            if (cat <= 6)      w = $urandom_range(MINT, MAXT);
            else if (cat <= 8) w = $urandom_range(0, MINT - 1);
            else               w = $urandom_range(MAXT + 1, MAXT + 30);
            h = w * TC + $urandom_range(0, TC - 1);
            if (h < 1) h = 1;
            pulse($sformatf("rnd%0d", i), h, $urandom_range(20, 200));
        end

        chk("valid_err_overlap", n_both, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
